hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage CPU. It resolves load-use hazards that the forwarding unit cannot cover, flushes on taken branches, and freezes the pipe while a multi-cycle data-memory access is pending. It drives the write-enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also keeps saturating stall and flush counters plus a sticky memory-timeout error.

---
 rtl/hazard_ctrl_if.sv | 41 ++++
 rtl/hazard_ctrl.sv | 109 ++++++++++
 tb/tb_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard controller signal bundle
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start_i;
    logic             ID_EX_MemRead_i;
    logic [4:0]       ID_EX_RTaddr_i;
    logic [4:0]       IF_ID_RSaddr_i;
    logic [4:0]       IF_ID_RTaddr_i;
    logic             Branch_taken_i;
    logic             dmem_req_i;
    logic             dmem_ack_i;
    logic             PC_Write_o;
    logic             IF_ID_Write_o;
    logic             IF_ID_Flush_o;
    logic             ID_EX_Write_o;
    logic             ID_EX_Flush_o;
    logic             EX_MEM_Write_o;
    logic             MEM_WB_Flush_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             err_o;

    // Pipeline side: presents hazard conditions, consumes stage controls
    modport master (
        output start_i, ID_EX_MemRead_i, ID_EX_RTaddr_i, IF_ID_RSaddr_i,
               IF_ID_RTaddr_i, Branch_taken_i, dmem_req_i, dmem_ack_i,
        input  PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Write_o,
               ID_EX_Flush_o, EX_MEM_Write_o, MEM_WB_Flush_o,
               stall_cnt_o, flush_cnt_o, err_o
    );

    // Controller side
    modport slave (
        input  start_i, ID_EX_MemRead_i, ID_EX_RTaddr_i, IF_ID_RSaddr_i,
               IF_ID_RTaddr_i, Branch_taken_i, dmem_req_i, dmem_ack_i,
        output PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Write_o,
               ID_EX_Flush_o, EX_MEM_Write_o, MEM_WB_Flush_o,
               stall_cnt_o, flush_cnt_o, err_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline stall/flush sequencing controller
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    hazard_ctrl_if.slave  hz
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic               r_err;

    logic w_mem_stall;
    logic w_load_use;

    assign w_mem_stall = hz.dmem_req_i & ~hz.dmem_ack_i;
    assign w_load_use  = hz.ID_EX_MemRead_i & (hz.ID_EX_RTaddr_i != 5'd0) &
                         ((hz.ID_EX_RTaddr_i == hz.IF_ID_RSaddr_i) |
                          (hz.ID_EX_RTaddr_i == hz.IF_ID_RTaddr_i));

    // State register; reset drops straight back to RUN even mid-access
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= RUN;
        else        r_state <= w_next_state;
    end

    // Next-state and stage controls; controls depend only on current inputs so
    // a hazard is acted on in the cycle it appears
    always_comb begin
        w_next_state      = r_state;
        hz.PC_Write_o     = 1'b1;
        hz.IF_ID_Write_o  = 1'b1;
        hz.IF_ID_Flush_o  = 1'b0;
        hz.ID_EX_Write_o  = 1'b1;
        hz.ID_EX_Flush_o  = 1'b0;
        hz.EX_MEM_Write_o = 1'b1;
        hz.MEM_WB_Flush_o = 1'b0;

        case (r_state)
            RUN:      if (w_mem_stall) w_next_state = MEM_WAIT;
            MEM_WAIT: if (!w_mem_stall) w_next_state = RUN;
            default:  w_next_state = RUN;
        endcase

        if (!hz.start_i) begin
            // Front end frozen, back end keeps draining
            hz.PC_Write_o    = 1'b0;
            hz.IF_ID_Write_o = 1'b0;
        end else if (w_mem_stall) begin
            hz.PC_Write_o     = 1'b0;
            hz.IF_ID_Write_o  = 1'b0;
            hz.ID_EX_Write_o  = 1'b0;
            hz.EX_MEM_Write_o = 1'b0;
            hz.MEM_WB_Flush_o = 1'b1;
        end else if (w_load_use) begin
            // Branch operands not ready; the branch re-resolves next cycle
            hz.PC_Write_o    = 1'b0;
            hz.IF_ID_Write_o = 1'b0;
            hz.ID_EX_Flush_o = 1'b1;
        end else if (hz.Branch_taken_i) begin
            hz.IF_ID_Flush_o = 1'b1;
        end
    end

    // Wait-cycle counter and sticky timeout; err rises as the count reaches TIMEOUT
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else if (!w_mem_stall) begin
            r_wait_cnt <= '0;
        end else if (r_state == RUN) begin
            r_wait_cnt <= WAIT_W'(1);
        end else begin
            if (r_wait_cnt != WAIT_W'(TIMEOUT))
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            if (r_wait_cnt == WAIT_W'(TIMEOUT - 1))
                r_err <= 1'b1;
        end
    end

    // Saturating event counters for stall cycles and taken-branch flushes
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (hz.start_i && !hz.PC_Write_o && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (hz.IF_ID_Flush_o && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign hz.stall_cnt_o = r_stall_cnt;
    assign hz.flush_cnt_o = r_flush_cnt;
    assign hz.err_o       = r_err;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    localparam int CNT_W = 3;

    // Output packing: {PC_W, IFID_W, IFID_F, IDEX_W, IDEX_F, EXMEM_W, MEMWB_F}
    localparam logic [6:0] NORM = 7'b1101010;
    localparam logic [6:0] HOLD = 7'b0001010;
    localparam logic [6:0] MEMS = 7'b0000001;
    localparam logic [6:0] LU   = 7'b0001110;
    localparam logic [6:0] BR   = 7'b1111010;

    typedef struct {
        string      name;
        logic       start;
        logic       mr;
        logic [4:0] ex_rt;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       br;
        logic       req;
        logic       ack;
        logic [6:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vecs[14];

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(4)) u_dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {hz.PC_Write_o, hz.IF_ID_Write_o, hz.IF_ID_Flush_o, hz.ID_EX_Write_o,
                hz.ID_EX_Flush_o, hz.EX_MEM_Write_o, hz.MEM_WB_Flush_o};
    endfunction

    function automatic vec_t mk(string name, logic start, logic mr, logic [4:0] ex_rt,
                                logic [4:0] id_rs, logic [4:0] id_rt, logic br,
                                logic req, logic ack, logic [6:0] exp);
        vec_t v;
        v.name = name; v.start = start; v.mr = mr; v.ex_rt = ex_rt;
        v.id_rs = id_rs; v.id_rt = id_rt; v.br = br; v.req = req; v.ack = ack;
        v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic start, input logic mr, input logic [4:0] ex_rt,
                         input logic [4:0] id_rs, input logic [4:0] id_rt,
                         input logic br, input logic req, input logic ack);
        hz.start_i         = start;
        hz.ID_EX_MemRead_i = mr;
        hz.ID_EX_RTaddr_i  = ex_rt;
        hz.IF_ID_RSaddr_i  = id_rs;
        hz.IF_ID_RTaddr_i  = id_rt;
        hz.Branch_taken_i  = br;
        hz.dmem_req_i      = req;
        hz.dmem_ack_i      = ack;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        vecs[0]  = mk("idle",       1, 0, 0, 0, 0, 0, 0, 0, NORM);
        vecs[1]  = mk("start0",     0, 0, 0, 0, 0, 0, 0, 0, HOLD);
        vecs[2]  = mk("start0_mem", 0, 0, 0, 0, 0, 0, 1, 0, HOLD);
        vecs[3]  = mk("mem_stall",  1, 0, 0, 0, 0, 0, 1, 0, MEMS);
        vecs[4]  = mk("lu_rs",      1, 1, 5, 5, 3, 0, 0, 0, LU);
        vecs[5]  = mk("lu_rt",      1, 1, 7, 2, 7, 0, 0, 0, LU);
        vecs[6]  = mk("lu_r0",      1, 1, 0, 0, 0, 0, 0, 0, NORM);
        vecs[7]  = mk("no_load",    1, 0, 5, 5, 5, 0, 0, 0, NORM);
        vecs[8]  = mk("no_match",   1, 1, 5, 6, 4, 0, 0, 0, NORM);
        vecs[9]  = mk("branch",     1, 0, 0, 0, 0, 1, 0, 0, BR);
        vecs[10] = mk("br_lu",      1, 1, 5, 5, 0, 1, 0, 0, LU);
        vecs[11] = mk("br_mem",     1, 1, 5, 5, 0, 1, 1, 0, MEMS);
        vecs[12] = mk("ack_same",   1, 0, 0, 0, 0, 0, 1, 1, NORM);
        vecs[13] = mk("start0_lu",  0, 1, 5, 5, 0, 1, 0, 0, HOLD);

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_stall_cnt", 32'(hz.stall_cnt_o), 0);
        chk("rst_flush_cnt", 32'(hz.flush_cnt_o), 0);
        chk("rst_err", 32'(hz.err_o), 0);
        chk("rst_outs", 32'(outs()), 32'(NORM));
        @(negedge clk);
        rst_n = 1'b1;

        // Combinational priority table
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].start, vecs[i].mr, vecs[i].ex_rt, vecs[i].id_rs,
                  vecs[i].id_rt, vecs[i].br, vecs[i].req, vecs[i].ack);
            #1;
            chk({"vec_", vecs[i].name}, 32'(outs()), 32'(vecs[i].exp));
        end
        @(negedge clk);
        chk("table_no_err", 32'(hz.err_o), 0);

        // Load-use single cycle, then r0 case
        do_reset();
        drive(1, 1, 5, 5, 0, 0, 0, 0);
        @(negedge clk);
        chk("lu_stall_cnt", 32'(hz.stall_cnt_o), 1);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("lu_r0_pc", 32'(hz.PC_Write_o), 1);
        @(negedge clk);
        chk("lu_r0_stall_cnt", 32'(hz.stall_cnt_o), 1);

        // Branch flush, then branch masked by load-use
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("br_flush_cnt", 32'(hz.flush_cnt_o), 1);
        drive(1, 1, 5, 5, 0, 1, 0, 0);
        #1;
        chk("br_lu_ifid_flush", 32'(hz.IF_ID_Flush_o), 0);
        chk("br_lu_idex_flush", 32'(hz.ID_EX_Flush_o), 1);
        @(negedge clk);
        chk("br_lu_flush_cnt", 32'(hz.flush_cnt_o), 1);
        chk("br_lu_stall_cnt", 32'(hz.stall_cnt_o), 1);

        // Memory wait of 3 cycles, release on ack, same-cycle ack, fresh wait
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_outs", 32'(outs()), 32'(MEMS));
            @(negedge clk);
        end
        drive(1, 0, 0, 0, 0, 0, 1, 1);
        #1;
        chk("mw_release", 32'(outs()), 32'(NORM));
        @(negedge clk);
        chk("mw_stall_cnt", 32'(hz.stall_cnt_o), 3);
        chk("mw_err", 32'(hz.err_o), 0);
        @(negedge clk);
        chk("same_ack_stall_cnt", 32'(hz.stall_cnt_o), 3);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("mw2_err", 32'(hz.err_o), 0);
        chk("mw2_stall_cnt", 32'(hz.stall_cnt_o), 6);

        // Abort: request drops without ack, then a new 3-cycle wait must not time out
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("abort_release", 32'(outs()), 32'(NORM));
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) @(negedge clk);
        chk("abort_no_err", 32'(hz.err_o), 0);

        // Timeout with TIMEOUT=4
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("to_pc_hold", 32'(hz.PC_Write_o), 0);
            chk("to_err", 32'(hz.err_o), (i >= 4) ? 1 : 0);
            @(negedge clk);
        end
        drive(1, 0, 0, 0, 0, 0, 1, 1);
        #1;
        chk("to_release", 32'(hz.PC_Write_o), 1);
        @(negedge clk);
        chk("to_err_sticky", 32'(hz.err_o), 1);
        chk("to_stall_cnt", 32'(hz.stall_cnt_o), 6);

        // Asynchronous reset mid-MEM_WAIT
        drive(1, 1, 5, 5, 0, 1, 1, 0);
        repeat (2) @(negedge clk);
        chk("pre_rst_cnt", 32'(hz.stall_cnt_o), 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_stall_cnt", 32'(hz.stall_cnt_o), 0);
        chk("arst_err", 32'(hz.err_o), 0);
        chk("arst_outs_mem", 32'(outs()), 32'(MEMS));
        drive(1, 1, 5, 5, 0, 1, 0, 0);
        #1;
        chk("arst_outs_lu", 32'(outs()), 32'(LU));
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation at 7
        do_reset();
        drive(1, 1, 9, 9, 0, 0, 0, 0);
        repeat (10) @(negedge clk);
        chk("sat_stall_cnt", 32'(hz.stall_cnt_o), 7);
        drive(1, 0, 0, 0, 0, 1, 0, 0);
        repeat (9) @(negedge clk);
        chk("sat_flush_cnt", 32'(hz.flush_cnt_o), 7);

        // start_i=0 with memory stall: front end held, back end drains, no stall count
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("s0_pc", 32'(hz.PC_Write_o), 0);
            chk("s0_exmem", 32'(hz.EX_MEM_Write_o), 1);
            @(negedge clk);
        end
        chk("s0_stall_cnt", 32'(hz.stall_cnt_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
